branch_predictor_bht: RTL
=========================

Name: branch_predictor_bht

Overview:
- Dynamic branch direction predictor that drives `branch_decision_take` into the fetch-stage program counter.
- Holds a direct-mapped table of 2-bit saturating counters indexed by instruction address.
- Updated by branch resolution from the ID/EX stage; flags mispredictions for PC redirect.
- After reset, runs a sweep FSM that initialises the table, plus saturating statistics counters.

Parameters:
- BHT_INDEX_WIDTH, 6, log2 of table entries (default 64 entries).
- BHT_INIT_STATE, 2'b01, counter value written by the init sweep (weakly not-taken).
- STAT_WIDTH, 16, width of the branch and mispredict statistics counters.
- INST_MEMORY_ADDRESS_WIDTH is taken from the shared package, not re-declared.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- lookup_addr, input, INST_MEMORY_ADDRESS_WIDTH, current fetch PC (`inst_addr`).
- predict_taken, output, 1, prediction for `lookup_addr`; drives `branch_decision_take`.
- resolve_valid, input, 1, a conditional branch resolved in EX this cycle.
- resolve_addr, input, INST_MEMORY_ADDRESS_WIDTH, PC of the resolved branch (`idex_branch_inst_addr`).
- resolve_taken, input, 1, actual branch outcome.
- resolve_predicted, input, 1, prediction carried down the pipe (`idex_branch_decision`).
- mispredict, output, 1, `resolve_valid` and (`resolve_taken` != `resolve_predicted`); drives `branch_decision_incorrect_flag`.
- init_busy, output, 1, high while the init sweep runs.
- branch_count, output, STAT_WIDTH, resolved branches counted.
- mispredict_count, output, STAT_WIDTH, mispredictions counted.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to INIT, sweep index = 0.
  - `init_busy` = 1, `predict_taken` = 0, both statistics counters = 0.
  - Table contents are not reset directly; the sweep initialises them.
- Index function: `idx(a)` = `a[BHT_INDEX_WIDTH+1:2]` (word-aligned PCs, bits [1:0] ignored).
  - Aliasing is permitted; there are no tags.
- FSM states:
  - INIT: each cycle writes BHT_INIT_STATE to the entry at sweep index, then increments the index. When index = 2^BHT_INDEX_WIDTH-1 is written, go to READY on the next edge. Sweep length is exactly 2^BHT_INDEX_WIDTH cycles after rst deasserts.
  - READY: normal operation; no exit except rst.
  - rst asserted mid-sweep or in READY restarts INIT from index 0.
- During INIT:
  - `predict_taken` = 0.
  - `resolve_valid` is ignored: no table update, no statistics change.
  - `mispredict` stays combinational from the resolve inputs (correctness of PC redirect does not depend on the table).
- Prediction (READY):
  - Combinational, zero latency: `predict_taken` = `table[idx(lookup_addr)][1]`.
- Update (READY, `resolve_valid`=1): one table write at the next posedge.
  - Taken: counter = min(counter+1, 3).
  - Not taken: counter = max(counter-1, 0).
  - Transitions: 00↔01↔10↔11; 11+taken stays 11; 00+not-taken stays 00.
- Same-cycle read/write to the same index:
  - Prediction returns the pre-update value (no bypass).
  - The new value is visible from the following cycle.
- `mispredict` is purely combinational, with no latency, so it is valid in the same cycle as `resolve_valid`.
- Statistics (READY, `resolve_valid`=1):
  - `branch_count` += 1.
  - `mispredict_count` += 1 if `mispredict`.
  - Both saturate at all-ones; no wrap.
- There is no `pc_hold` input: the EX stage must present `resolve_valid` for exactly one cycle per resolved branch, including during stalls.

Decomposition:
- Shared package holds:
  - `INST_MEMORY_ADDRESS_WIDTH`.
  - `typedef enum logic {BHT_INIT, BHT_READY} bht_state_t`.
  - `typedef logic [1:0] bht_ctr_t`.
  - Constants `BHT_STRONG_NT`=2'b00, `BHT_WEAK_NT`=2'b01, `BHT_WEAK_T`=2'b10, `BHT_STRONG_T`=2'b11.
- One natural sub-module: `sat_counter_2b`, a combinational next-state for a 2-bit saturating counter (inputs counter and taken; output next counter). It is instantiated once on the write path.
- The table is a plain register array: one combinational read port, one synchronous write port muxed between the sweep and update paths.

Test Plan:
- Init sweep: deassert rst.
  - `init_busy`=1 for exactly 64 cycles, then 0.
  - During the sweep, `resolve_valid`=1 with taken=1 leaves `branch_count`=0.
  - After the sweep, `predict_taken`=0 for every `lookup_addr` 0x000..0x0FC.
- Training: resolve addr 0x40 taken on two consecutive cycles.
  - `predict_taken` at `lookup_addr` 0x40 goes 0→1 (counter 01→10→11).
  - Two not-taken resolves: 11→10→01, prediction back to 0 only after the second.
- Saturation: five not-taken resolves at 0x80, then one taken.
  - Counter 00 then 01, `predict_taken` stays 0.
  - Five taken resolves then one not-taken: 11 then 10, `predict_taken` stays 1.
- Mispredict/stats: `resolve_predicted`=1, `resolve_taken`=0 at 0x10.
  - `mispredict`=1 in the same cycle.
  - Next cycle: `branch_count`=1, `mispredict_count`=1.
  - Force `branch_count` to 0xFFFF; one more resolve leaves it at 0xFFFF.
- Same-index collision: `lookup_addr`=resolve_addr=0x20, counter 01, `resolve_taken`=1.
  - `predict_taken`=0 this cycle, 1 next cycle.
- Aliasing and reset: train 0x04 and 0x104 (same index); both predict from a shared counter.
  - Assert rst mid-sweep at index 30: `init_busy` stays high for a full 64 cycles after release, and the statistics read 0.

Source files
------------

// File: rtl/branch_predictor_bht_pkg.sv
// rtl/branch_predictor_bht_pkg.sv - shared types and constants for the branch history table
package branch_predictor_bht_pkg;

    localparam int INST_MEMORY_ADDRESS_WIDTH = 32;

    typedef enum logic {BHT_INIT, BHT_READY} bht_state_t;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_STRONG_NT = 2'b00;
    localparam bht_ctr_t BHT_WEAK_NT   = 2'b01;
    localparam bht_ctr_t BHT_WEAK_T    = 2'b10;
    localparam bht_ctr_t BHT_STRONG_T  = 2'b11;

endpackage

// File: rtl/branch_predictor_bht_sat_counter_2b.sv
// rtl/branch_predictor_bht_sat_counter_2b.sv - combinational next state of a 2-bit saturating counter
module sat_counter_2b
    import branch_predictor_bht_pkg::*;
(
    input  bht_ctr_t counter,
    input  logic     taken,
    output bht_ctr_t next_counter
);

    always_comb begin
        next_counter = counter;
        if (taken) begin
            if (counter != BHT_STRONG_T) next_counter = counter + 2'd1;
        end else begin
            if (counter != BHT_STRONG_NT) next_counter = counter - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - direct-mapped 2-bit branch history table with init sweep and statistics
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int       BHT_INDEX_WIDTH = 6,
    parameter bht_ctr_t BHT_INIT_STATE  = 2'b01,
    parameter int       STAT_WIDTH      = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] lookup_addr,
    output logic                                 predict_taken,
    input  logic                                 resolve_valid,
    input  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] resolve_addr,
    input  logic                                 resolve_taken,
    input  logic                                 resolve_predicted,
    output logic                                 mispredict,
    output logic                                 init_busy,
    output logic [STAT_WIDTH-1:0]                branch_count,
    output logic [STAT_WIDTH-1:0]                mispredict_count
);

    localparam int BHT_ENTRIES = 1 << BHT_INDEX_WIDTH;

    bht_state_t                 state, next_state;
    logic [BHT_INDEX_WIDTH-1:0] sweep_idx;
    bht_ctr_t                   bht_table [BHT_ENTRIES];

    logic [BHT_INDEX_WIDTH-1:0] lookup_idx, resolve_idx, wr_idx;
    bht_ctr_t                   upd_ctr, wr_data;
    logic                       wr_en, ready_update;

    // PCs are word aligned; the low two bits and the bits above the index never select an entry.
    assign lookup_idx  = lookup_addr[BHT_INDEX_WIDTH+1:2];
    assign resolve_idx = resolve_addr[BHT_INDEX_WIDTH+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{lookup_addr[INST_MEMORY_ADDRESS_WIDTH-1:BHT_INDEX_WIDTH+2],
                                lookup_addr[1:0],
                                resolve_addr[INST_MEMORY_ADDRESS_WIDTH-1:BHT_INDEX_WIDTH+2],
                                resolve_addr[1:0]};

    assign mispredict    = resolve_valid && (resolve_taken != resolve_predicted);
    assign init_busy     = (state == BHT_INIT);
    assign predict_taken = (state == BHT_READY) && bht_table[lookup_idx][1];
    assign ready_update  = (state == BHT_READY) && resolve_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BHT_INIT;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (state == BHT_INIT && sweep_idx == '1) next_state = BHT_READY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   sweep_idx <= '0;
        else if (state == BHT_INIT) sweep_idx <= sweep_idx + BHT_INDEX_WIDTH'(1);
    end

    sat_counter_2b u_sat_counter (
        .counter      (bht_table[resolve_idx]),
        .taken        (resolve_taken),
        .next_counter (upd_ctr)
    );

    // Single write port: the sweep owns it during INIT, resolved branches afterwards.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = sweep_idx;
        wr_data = BHT_INIT_STATE;
        if (state == BHT_INIT) begin
            wr_en = 1'b1;
        end else if (resolve_valid) begin
            wr_en   = 1'b1;
            wr_idx  = resolve_idx;
            wr_data = upd_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) bht_table[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (ready_update) begin
            if (branch_count != '1) branch_count <= branch_count + STAT_WIDTH'(1);
            if (mispredict && mispredict_count != '1)
                mispredict_count <= mispredict_count + STAT_WIDTH'(1);
        end
    end

endmodule
